mbscore_muldiv_unit: RTL

Iterative 32-bit multiply/divide unit with architectural HI/LO registers. It consumes the two ALU operand buses produced by the operand mux (`alu_in_a`, `alu_in_b`) and runs MULT/MULTU/DIV/DIVU over multiple cycles. It asserts `busy` so the pipeline stalls HI/LO readers, and it services MTHI/MTLO writes. It sits in the EX stage beside the single-cycle ALU.

---
 rtl/mbscore_muldiv_unit.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mbscore_muldiv_unit.sv
// ============================================================================
//  Module   : mbscore_muldiv_unit
//  Purpose  : Iterative 32-bit multiply/divide unit with architectural HI/LO
//             registers. Runs MULT/MULTU (radix-2 shift-add) and DIV/DIVU
//             (restoring shift-subtract) over DATA_WIDTH+2 cycles, stalls the
//             pipeline through busy, and services MTHI/MTLO writes.
//  Ports    : clk, rst (async, active-high)
//             start, op[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//             op_a, op_b    - operands from the ALU operand buses
//             flush         - abort the in-flight operation
//             hi_we, lo_we, wdata - MTHI/MTLO write port
//             busy, done    - operation in flight / one-cycle completion pulse
//             hi, lo        - HI/LO register outputs
//  Config   : define MBSCORE_DIV_EN to build the divider datapath; without it
//             DIV/DIVU requests are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mbscore_muldiv_unit #(
   parameter int DATA_WIDTH = `DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   input  logic                  flush,
   input  logic                  hi_we,
   input  logic                  lo_we,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_WIDTH - 1);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_mul  = 2'd1;
`ifdef MBSCORE_DIV_EN
   localparam logic [1:0] c_st_div  = 2'd2;
`endif
   localparam logic [1:0] c_st_fix  = 2'd3;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]              r_state;
   logic [CNT_W-1:0]        r_cnt;
   // Multiply: {partial product high, multiplier/product low}.
   // Divide:   {partial remainder, dividend shifting out / quotient in}.
   logic [2*DATA_WIDTH-1:0] r_acc;
   // Multiplicand magnitude or divisor magnitude.
   logic [DATA_WIDTH-1:0]   r_opnd;
   logic                    r_neg_q;     // negate product / quotient
   logic [DATA_WIDTH-1:0]   r_hi;
   logic [DATA_WIDTH-1:0]   r_lo;
   logic                    r_done;
`ifdef MBSCORE_DIV_EN
   logic                    r_is_div;
   logic                    r_neg_r;     // negate remainder (dividend sign)
   logic                    r_div_zero;
`endif

   // ------------------------------------------------------------------------
   // Operand conditioning in IDLE
   // ------------------------------------------------------------------------
   logic                  w_signed;
   logic                  w_sa;
   logic                  w_sb;
   logic [DATA_WIDTH-1:0] w_mag_a;
   logic [DATA_WIDTH-1:0] w_mag_b;
   logic                  w_take;

   assign w_signed = ~op[0];
   assign w_sa     = w_signed & op_a[DATA_WIDTH-1];
   assign w_sb     = w_signed & op_b[DATA_WIDTH-1];
   // The most negative value maps onto itself, which is the correct
   // unsigned magnitude.
   assign w_mag_a  = w_sa ? (-op_a) : op_a;
   assign w_mag_b  = w_sb ? (-op_b) : op_b;

   // flush in IDLE suppresses a simultaneous start.
`ifdef MBSCORE_DIV_EN
   assign w_take = start & ~flush;
`else
   assign w_take = start & ~flush & ~op[1];
`endif

   // ------------------------------------------------------------------------
   // Multiply step: add multiplicand into the high half when the current
   // multiplier bit is set, then shift the whole accumulator right by one.
   // The carry out of the add becomes the new top bit.
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH:0]     w_mul_sum;
   logic [2*DATA_WIDTH-1:0] w_mul_next;

   assign w_mul_sum  = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opnd} : {(DATA_WIDTH+1){1'b0}});
   assign w_mul_next = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};

`ifdef MBSCORE_DIV_EN
   // ------------------------------------------------------------------------
   // Divide step: shift the next dividend bit into the partial remainder,
   // subtract the divisor when it fits and record the quotient bit.
   // The shifted remainder needs DATA_WIDTH+1 bits; after a successful
   // subtract it always fits back into DATA_WIDTH bits.
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH:0]     w_div_shift;
   logic                    w_div_ge;
   logic [DATA_WIDTH-1:0]   w_div_rem;
   logic [2*DATA_WIDTH-1:0] w_div_next;

   assign w_div_shift = r_acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
   assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
   assign w_div_rem   = w_div_ge ? (w_div_shift[DATA_WIDTH-1:0] - r_opnd)
                                 : w_div_shift[DATA_WIDTH-1:0];
   assign w_div_next  = {w_div_rem, r_acc[DATA_WIDTH-2:0], w_div_ge};
`endif

   // ------------------------------------------------------------------------
   // Sign correction applied in FIX
   // ------------------------------------------------------------------------
   logic [2*DATA_WIDTH-1:0] w_prod_fix;
   assign w_prod_fix = r_neg_q ? (-r_acc) : r_acc;

`ifdef MBSCORE_DIV_EN
   logic [DATA_WIDTH-1:0] w_quo_raw;
   logic [DATA_WIDTH-1:0] w_rem_raw;
   logic [DATA_WIDTH-1:0] w_quo_fix;
   logic [DATA_WIDTH-1:0] w_rem_fix;

   assign w_quo_raw = r_acc[DATA_WIDTH-1:0];
   assign w_rem_raw = r_acc[2*DATA_WIDTH-1:DATA_WIDTH];
   // Division by zero leaves the remainder equal to the dividend magnitude,
   // so the usual remainder sign fix already restores op_a; only the
   // quotient needs forcing to all ones.
   assign w_quo_fix = r_div_zero ? {DATA_WIDTH{1'b1}}
                    : (r_neg_q ? (-w_quo_raw) : w_quo_raw);
   assign w_rem_fix = r_neg_r ? (-w_rem_raw) : w_rem_raw;
`endif

   // ------------------------------------------------------------------------
   // Sequencer and HI/LO registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_st_idle;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_opnd     <= '0;
         r_neg_q    <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
`ifdef MBSCORE_DIV_EN
         r_is_div   <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_st_idle: begin
               // MTHI/MTLO land here even when a start is taken in the same
               // cycle; the operation result overwrites them later.
               if (hi_we) r_hi <= wdata;
               if (lo_we) r_lo <= wdata;
               if (w_take) begin
                  r_cnt   <= c_cnt_last;
                  r_neg_q <= w_sa ^ w_sb;
`ifdef MBSCORE_DIV_EN
                  r_is_div   <= op[1];
                  r_neg_r    <= w_sa;
                  r_div_zero <= (op_b == '0);
                  if (op[1]) begin
                     r_acc   <= {{DATA_WIDTH{1'b0}}, w_mag_a};
                     r_opnd  <= w_mag_b;
                     r_state <= c_st_div;
                  end else begin
                     r_acc   <= {{DATA_WIDTH{1'b0}}, w_mag_b};
                     r_opnd  <= w_mag_a;
                     r_state <= c_st_mul;
                  end
`else
                  r_acc   <= {{DATA_WIDTH{1'b0}}, w_mag_b};
                  r_opnd  <= w_mag_a;
                  r_state <= c_st_mul;
`endif
               end
            end

            c_st_mul: begin
               if (flush) begin
                  r_state <= c_st_idle;
               end else begin
                  r_acc <= w_mul_next;
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_cnt == '0) r_state <= c_st_fix;
               end
            end

`ifdef MBSCORE_DIV_EN
            c_st_div: begin
               if (flush) begin
                  r_state <= c_st_idle;
               end else begin
                  r_acc <= w_div_next;
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_cnt == '0) r_state <= c_st_fix;
               end
            end
`endif

            c_st_fix: begin
               r_state <= c_st_idle;
               if (!flush) begin
`ifdef MBSCORE_DIV_EN
                  if (r_is_div) begin
                     r_hi <= w_rem_fix;
                     r_lo <= w_quo_fix;
                  end else begin
                     r_hi <= w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
                     r_lo <= w_prod_fix[DATA_WIDTH-1:0];
                  end
`else
                  r_hi <= w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
                  r_lo <= w_prod_fix[DATA_WIDTH-1:0];
`endif
                  r_done <= 1'b1;
               end
            end

            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign busy = (r_state != c_st_idle);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

`default_nettype wire
